trace_buffer: RTL and testbench

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_buffer.sv | 123 ++++++++++++
 tb/tb_trace_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// Timestamped capture FIFO: stores {cap_data, ts} words and pops the oldest one on request.
// Optional sticky loss flag enabled by defining TRACE_BUFFER_OVF_EN; otherwise overflow is tied to 0.
module trace_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int TS_W   = 32,
  parameter int WRAP   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       cap_valid,
  input  logic [DATA_W-1:0]          cap_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic [TS_W-1:0]            rd_ts,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [TS_W-1:0]   mem_ts   [DEPTH];

  logic [TS_W-1:0]  ts;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic do_pop;
  logic cap_at_full;
  logic wr_acc;
  logic ovwr;

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

  // A full buffer only loses data when nothing is popped in the same cycle.
  assign do_pop      = rd_en & ~empty;
  assign cap_at_full = cap_valid & full & ~do_pop;
  assign ovwr        = cap_at_full & (WRAP != 0);
  assign wr_acc      = cap_valid & (~cap_at_full | (WRAP != 0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop || ovwr) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_acc & ~ovwr, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Popped word is registered; it holds until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      rd_ts   <= '0;
    end else if (do_pop && !clear) begin
      rd_data <= mem_data[rd_ptr];
      rd_ts   <= mem_ts[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !clear) begin
      mem_data[wr_ptr] <= cap_data;
      mem_ts[wr_ptr]   <= ts;
    end
  end

`ifdef TRACE_BUFFER_OVF_EN
  logic ovf;
  logic lost;

  assign lost     = cap_at_full;
  assign overflow = ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (clear) begin
      ovf <= 1'b0;
    end else if (lost) begin
      ovf <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: one WRAP=1 and one WRAP=0 instance share stimulus and are
// checked against a queue-based reference model, a vector table and directed sequences.
module tb_trace_buffer;

`ifdef TRACE_BUFFER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  t;
  } ent_t;

  typedef struct {
    logic        cap;
    logic        rd;
    logic        clr;
    logic [15:0] d;
    int          cnt;
    logic        rvld;
    logic        chkd;
    logic [15:0] ew;
    logic [15:0] ed;
    logic        ovf;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        cap_valid;
  logic [15:0] cap_data;
  logic        rd_en;

  logic        o_rvld  [2];
  logic [15:0] o_rdata [2];
  logic [7:0]  o_rts   [2];
  logic [2:0]  o_cnt   [2];
  logic        o_empty [2];
  logic        o_full  [2];
  logic        o_ovf   [2];

  // reference model: index 0 = WRAP=1, index 1 = WRAP=0
  ent_t        mq [2][$];
  logic [7:0]  m_ts;
  logic        m_ovf   [2];
  logic        m_rvld  [2];
  logic [15:0] m_rdata [2];
  logic [7:0]  m_rts   [2];

  int checks;
  int errors;

  trace_buffer #(.DATA_W(16), .DEPTH(DEPTH), .TS_W(8), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .clear(clear), .cap_valid(cap_valid), .cap_data(cap_data),
    .rd_en(rd_en), .rd_valid(o_rvld[0]), .rd_data(o_rdata[0]), .rd_ts(o_rts[0]),
    .count(o_cnt[0]), .empty(o_empty[0]), .full(o_full[0]), .overflow(o_ovf[0])
  );

  trace_buffer #(.DATA_W(16), .DEPTH(DEPTH), .TS_W(8), .WRAP(0)) u_drop (
    .clk(clk), .rst(rst), .clear(clear), .cap_valid(cap_valid), .cap_data(cap_data),
    .rd_en(rd_en), .rd_valid(o_rvld[1]), .rd_data(o_rdata[1]), .rd_ts(o_rts[1]),
    .count(o_cnt[1]), .empty(o_empty[1]), .full(o_full[1]), .overflow(o_ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_ovf[i]   = 1'b0;
      m_rvld[i]  = 1'b0;
      m_rdata[i] = 16'h0;
      m_rts[i]   = 8'h0;
    end
    m_ts = 8'h0;
  endtask

  task automatic model_update(input logic c, input logic [15:0] d, input logic r, input logic cl);
    ent_t e;
    ent_t p;
    e.d = d;
    e.t = m_ts;
    for (int i = 0; i < 2; i++) begin
      if (cl) begin
        mq[i].delete();
        m_ovf[i]  = 1'b0;
        m_rvld[i] = 1'b0;
      end else begin
        m_rvld[i] = 1'b0;
        if (r && mq[i].size() > 0) begin
          p = mq[i].pop_front();
          m_rvld[i]  = 1'b1;
          m_rdata[i] = p.d;
          m_rts[i]   = p.t;
        end
        if (c) begin
          if (mq[i].size() < DEPTH) begin
            mq[i].push_back(e);
          end else begin
            m_ovf[i] = 1'b1;
            if (i == 0) begin
              p = mq[i].pop_front();
              mq[i].push_back(e);
            end
          end
        end
      end
    end
    m_ts = m_ts + 8'd1;
  endtask

  task automatic compare_model();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_count[%0d]", i), 32'(o_cnt[i]), 32'(mq[i].size()));
      chk($sformatf("model_empty[%0d]", i), 32'(o_empty[i]), 32'(mq[i].size() == 0));
      chk($sformatf("model_full[%0d]", i), 32'(o_full[i]), 32'(mq[i].size() == DEPTH));
      chk($sformatf("model_rvld[%0d]", i), 32'(o_rvld[i]), 32'(m_rvld[i]));
      chk($sformatf("model_rdata[%0d]", i), 32'(o_rdata[i]), 32'(m_rdata[i]));
      chk($sformatf("model_rts[%0d]", i), 32'(o_rts[i]), 32'(m_rts[i]));
      chk($sformatf("model_ovf[%0d]", i), 32'(o_ovf[i]), 32'(m_ovf[i] & OVF_EN));
    end
  endtask

  task automatic step(input logic c, input logic [15:0] d, input logic r, input logic cl);
    cap_valid = c;
    cap_data  = d;
    rd_en     = r;
    clear     = cl;
    @(posedge clk);
    model_update(c, d, r, cl);
    #1;
    compare_model();
  endtask

  vec_t       tbl [11];
  logic [7:0] t_exp;
  int         guard;

  initial begin
    checks = 0;
    errors = 0;
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'hA0A0, 1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'hB0B0, 2, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'hC0C0, 3, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'hD0D0, 4, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'hE0E0, 4, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 3, 1'b1, 1'b1, 16'hB0B0, 16'hA0A0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 2, 1'b1, 1'b1, 16'hC0C0, 16'hB0B0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, 1'b1, 1'b1, 16'hD0D0, 16'hC0C0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b1, 16'hE0E0, 16'hD0D0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b1, 16'hE0E0, 16'hD0D0, 1'b1};

    rst = 1'b1; clear = 1'b0; cap_valid = 1'b0; cap_data = 16'h0; rd_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model();
    rst = 1'b0;

    // first capture at ts=5, popped two cycles later
    repeat (5) step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("first_count_after_cap", 32'(o_cnt[0]), 32'd1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("first_rvld", 32'(o_rvld[0]), 32'd1);
    chk("first_rdata", 32'(o_rdata[0]), 32'h1234);
    chk("first_rts", 32'(o_rts[0]), 32'd5);
    chk("first_count_after_pop", 32'(o_cnt[0]), 32'd0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("first_rvld_pulse_end", 32'(o_rvld[0]), 32'd0);

    // five captures into a depth-4 buffer, then drain
    for (int k = 0; k < 11; k++) begin
      step(tbl[k].cap, tbl[k].d, tbl[k].rd, tbl[k].clr);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("tbl%0d_count[%0d]", k, i), 32'(o_cnt[i]), 32'(tbl[k].cnt));
        chk($sformatf("tbl%0d_full[%0d]", k, i), 32'(o_full[i]), 32'(tbl[k].cnt == DEPTH));
        chk($sformatf("tbl%0d_empty[%0d]", k, i), 32'(o_empty[i]), 32'(tbl[k].cnt == 0));
        chk($sformatf("tbl%0d_rvld[%0d]", k, i), 32'(o_rvld[i]), 32'(tbl[k].rvld));
        chk($sformatf("tbl%0d_ovf[%0d]", k, i), 32'(o_ovf[i]), 32'(tbl[k].ovf & OVF_EN));
        if (tbl[k].chkd)
          chk($sformatf("tbl%0d_rdata[%0d]", k, i), 32'(o_rdata[i]),
              32'((i == 0) ? tbl[k].ew : tbl[k].ed));
      end
    end

    // full buffer with simultaneous capture and pop loses nothing
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 16'hF001, 1'b0, 1'b0);
    step(1'b1, 16'hF002, 1'b0, 1'b0);
    step(1'b1, 16'hF003, 1'b0, 1'b0);
    step(1'b1, 16'hF004, 1'b0, 1'b0);
    step(1'b1, 16'h5555, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("full_both_rvld[%0d]", i), 32'(o_rvld[i]), 32'd1);
      chk($sformatf("full_both_rdata[%0d]", i), 32'(o_rdata[i]), 32'hF001);
      chk($sformatf("full_both_count[%0d]", i), 32'(o_cnt[i]), 32'd4);
      chk($sformatf("full_both_ovf[%0d]", i), 32'(o_ovf[i]), 32'd0);
    end

    // pop on empty, then clear with three entries stored
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("empty_pop_rvld", 32'(o_rvld[0]), 32'd0);
    chk("empty_pop_count", 32'(o_cnt[0]), 32'd0);
    step(1'b1, 16'h3131, 1'b0, 1'b0);
    step(1'b1, 16'h3232, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 1'b0);
    chk("pre_clear_count", 32'(o_cnt[0]), 32'd3);
    t_exp = m_ts + 8'd1;
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("clear_count", 32'(o_cnt[0]), 32'd0);
    chk("clear_empty", 32'(o_empty[0]), 32'd1);
    chk("clear_ovf", 32'(o_ovf[0]), 32'd0);
    step(1'b1, 16'h3636, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("clear_ts_continues", 32'(o_rts[0]), 32'(t_exp));

    // timestamp wrap: capture sampled in the cycle after ts=FF
    step(1'b0, 16'h0, 1'b0, 1'b1);
    guard = 0;
    while (m_ts != 8'hFF && guard < 300) begin
      step(1'b0, 16'h0, 1'b0, 1'b0);
      guard++;
    end
    chk("ts_reach_ff", 32'(m_ts), 32'hFF);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h7777, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("ts_wrap_rts", 32'(o_rts[0]), 32'h00);
    chk("ts_wrap_rdata", 32'(o_rdata[0]), 32'h7777);

    // asynchronous reset in the middle of traffic
    step(1'b1, 16'h8181, 1'b0, 1'b0);
    step(1'b1, 16'h8282, 1'b0, 1'b0);
    step(1'b1, 16'h8383, 1'b1, 1'b0);
    cap_valid = 1'b0; rd_en = 1'b0; clear = 1'b0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arst_count[%0d]", i), 32'(o_cnt[i]), 32'd0);
      chk($sformatf("arst_empty[%0d]", i), 32'(o_empty[i]), 32'd1);
      chk($sformatf("arst_full[%0d]", i), 32'(o_full[i]), 32'd0);
      chk($sformatf("arst_rvld[%0d]", i), 32'(o_rvld[i]), 32'd0);
      chk($sformatf("arst_rdata[%0d]", i), 32'(o_rdata[i]), 32'd0);
      chk($sformatf("arst_rts[%0d]", i), 32'(o_rts[i]), 32'd0);
      chk($sformatf("arst_ovf[%0d]", i), 32'(o_ovf[i]), 32'd0);
    end
    model_reset();
    #2;
    rst = 1'b0;
    step(1'b1, 16'h0101, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("post_rst_rts", 32'(o_rts[0]), 32'd0);
    chk("post_rst_rdata", 32'(o_rdata[0]), 32'h0101);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) < 55), 16'($urandom),
           ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
